// File: rtl/uart_pkg.sv
// Purpose : shared types and character constants for the uart command responder.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // Line-protocol engine states.
  typedef enum logic [2:0] {
    RECV    = 3'd0,
    DISCARD = 3'd1,
    ECHO    = 3'd2,
    SEP     = 3'd3,
    RSP     = 3'd4,
    TERM    = 3'd5
  } state_t;

  localparam logic [7:0] CHAR_TERM = 8'h3B;  // ';'
  localparam logic [7:0] CHAR_SEP  = 8'h3A;  // ':'

endpackage

// File: rtl/uart_tx_req.sv
// Purpose : single-byte transmit handshake towards the uart tx side.
// Latency : i_load -> o_tx_start one cycle later; o_done is combinational on the accepted i_tx_done.
// Backpressure: i_load is ignored while o_busy; tx_start held until tx_active is seen high.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   i_load, i_data       request to send one word (taken only when not busy)
//   i_tx_active, i_tx_done  status from the uart
//   o_tx_start, o_tx_word   request to the uart; word is stable for the whole transaction
//   o_busy               a transaction is outstanding
//   o_done               1-cycle pulse when the outstanding transaction's tx_done arrives
module uart_tx_req #(
  parameter int DataBits = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_load,
  input  logic [DataBits-1:0] i_data,
  input  logic                i_tx_active,
  input  logic                i_tx_done,
  output logic                o_tx_start,
  output logic [DataBits-1:0] o_tx_word,
  output logic                o_busy,
  output logic                o_done
);

  logic                r_start;
  logic                r_busy;
  logic [DataBits-1:0] r_word;
  logic                w_done;

  // tx_done is only meaningful once the uart has taken the word (start dropped);
  // a tx_done seen with no outstanding transaction (e.g. left over from before a
  // reset) is ignored.
  assign w_done = r_busy && !r_start && i_tx_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_word  <= '0;
    end else if (i_load && !r_busy) begin
      r_word  <= i_data;
      r_start <= 1'b1;
      r_busy  <= 1'b1;
    end else begin
      if (r_start && i_tx_active) begin
        r_start <= 1'b0;
      end
      if (w_done) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_tx_start = r_start;
  assign o_tx_word  = r_word;
  assign o_busy     = r_busy;
  assign o_done     = w_done;

endmodule

// File: rtl/uart_cmd_responder.sv
// Purpose : slave line-protocol engine: collect "cmd;" then send "cmd:" + response + ";".
// Latency : Terminator rx_done in cycle N -> tx_start with the first echoed byte in cycle N+1.
// Backpressure: response bytes taken via rsp_valid/rsp_ready, one per uart word; rx is gated off while transmitting.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   o_rx_enable                   to uart; receive allowed only in RECV/DISCARD with the line idle
//   i_rx_word/_error/_done/_active  receive side of the uart
//   o_tx_start, o_tx_word         transmit request to the uart
//   i_tx_done, i_tx_active        transmit status from the uart
//   o_cmd_valid, o_cmd_len        a complete command is buffered, and its length
//   i_cmd_rd_addr, o_cmd_rd_data  combinational read port into the command buffer
//   i_rsp_valid/_data/_last, o_rsp_ready  response byte stream from user logic
//   o_cmd_err                     1-cycle pulse when a message was discarded
module uart_cmd_responder
  import uart_pkg::*;
#(
  parameter int                  DataBits   = 8,
  parameter int                  MaxLen     = 16,
  parameter logic [DataBits-1:0] Terminator = DataBits'(CHAR_TERM),
  parameter logic [DataBits-1:0] Separator  = DataBits'(CHAR_SEP),
  localparam int                 LW         = $clog2(MaxLen + 1),
  localparam int                 AW         = (MaxLen > 1) ? $clog2(MaxLen) : 1
) (
  input  logic                clk,
  input  logic                reset,
  output logic                o_rx_enable,
  input  logic [DataBits-1:0] i_rx_word,
  input  logic                i_rx_error,
  input  logic                i_rx_done,
  input  logic                i_rx_active,
  output logic                o_tx_start,
  output logic [DataBits-1:0] o_tx_word,
  input  logic                i_tx_done,
  input  logic                i_tx_active,
  output logic                o_cmd_valid,
  output logic [LW-1:0]       o_cmd_len,
  input  logic [AW-1:0]       i_cmd_rd_addr,
  output logic [DataBits-1:0] o_cmd_rd_data,
  input  logic                i_rsp_valid,
  input  logic [DataBits-1:0] i_rsp_data,
  input  logic                i_rsp_last,
  output logic                o_rsp_ready,
  output logic                o_cmd_err
);

  localparam logic [LW-1:0] MAX_LEN = LW'(MaxLen);

  state_t              r_state;
  logic [LW-1:0]       r_len;
  logic [LW-1:0]       r_idx;      // next echo byte to load
  logic                r_cmd_valid;
  logic                r_last;     // the response byte in flight is the final one
  logic                r_term_ld;  // closing Terminator has been handed to the tx handshake
  logic                r_cmd_err;
  logic [DataBits-1:0] r_buf [MaxLen];

  state_t              w_state_nxt;
  logic [LW-1:0]       w_len_nxt;
  logic [LW-1:0]       w_idx_nxt;
  logic                w_cmd_valid_nxt;
  logic                w_last_nxt;
  logic                w_term_ld_nxt;
  logic                w_cmd_err_nxt;
  logic                w_buf_we;
  logic                w_load;
  logic [DataBits-1:0] w_load_dat;
  logic                w_busy;
  logic                w_done;
  logic                w_can_load;
  logic                w_is_term;
  logic                w_rsp_rdy;
  logic                w_rsp_acc;

  uart_tx_req #(
    .DataBits(DataBits)
  ) u_tx_req (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_data     (w_load_dat),
    .i_tx_active(i_tx_active),
    .i_tx_done  (i_tx_done),
    .o_tx_start (o_tx_start),
    .o_tx_word  (o_tx_word),
    .o_busy     (w_busy),
    .o_done     (w_done)
  );

  // A new word is never started while the master is mid-word on the line.
  assign w_can_load = !w_busy && !i_rx_active;
  assign w_is_term  = (i_rx_word == Terminator);
  assign w_rsp_rdy  = (r_state == RSP) && !w_busy && !i_tx_active && !i_rx_active;
  assign w_rsp_acc  = w_rsp_rdy && i_rsp_valid;

  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_idx_nxt       = r_idx;
    w_cmd_valid_nxt = r_cmd_valid;
    w_last_nxt      = r_last;
    w_term_ld_nxt   = r_term_ld;
    w_cmd_err_nxt   = 1'b0;
    w_buf_we        = 1'b0;
    w_load          = 1'b0;
    w_load_dat      = '0;

    case (r_state)
      RECV: begin
        if (i_rx_done) begin
          if (i_rx_error) begin
            w_state_nxt = DISCARD;
          end else if (w_is_term) begin
            // An empty message is silently ignored.
            if (r_len != '0) begin
              w_state_nxt = ECHO;
              // Start the first echo byte straight away to meet the N+1 latency.
              if (w_can_load) begin
                w_load     = 1'b1;
                w_load_dat = r_buf[0];
                w_idx_nxt  = LW'(1);
              end else begin
                w_idx_nxt  = '0;
              end
            end
          end else if (r_len < MAX_LEN) begin
            w_buf_we  = 1'b1;
            w_len_nxt = r_len + LW'(1);
          end else begin
            w_state_nxt = DISCARD;
          end
        end
      end

      DISCARD: begin
        if (i_rx_done && !i_rx_error && w_is_term) begin
          w_cmd_err_nxt = 1'b1;
          w_len_nxt     = '0;
          w_state_nxt   = RECV;
        end
      end

      ECHO: begin
        // Handshake idle with idx == len means the last echo byte has completed.
        if (w_can_load) begin
          w_load = 1'b1;
          if (r_idx < r_len) begin
            w_load_dat = r_buf[r_idx[AW-1:0]];
            w_idx_nxt  = r_idx + LW'(1);
          end else begin
            w_load_dat  = Separator;
            w_state_nxt = SEP;
          end
        end
      end

      SEP: begin
        if (w_done) begin
          w_state_nxt     = RSP;
          w_cmd_valid_nxt = 1'b1;
          w_last_nxt      = 1'b0;
        end
      end

      RSP: begin
        if (w_rsp_acc) begin
          w_load     = 1'b1;
          w_load_dat = i_rsp_data;
          w_last_nxt = i_rsp_last;
        end
        if (w_done && r_last) begin
          w_state_nxt     = TERM;
          w_cmd_valid_nxt = 1'b0;
          w_term_ld_nxt   = 1'b0;
        end
      end

      TERM: begin
        if (!r_term_ld) begin
          if (w_can_load) begin
            w_load        = 1'b1;
            w_load_dat    = Terminator;
            w_term_ld_nxt = 1'b1;
          end
        end else if (w_done) begin
          w_term_ld_nxt = 1'b0;
          w_len_nxt     = '0;
          w_state_nxt   = RECV;
        end
      end

      default: begin
        w_state_nxt = RECV;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RECV;
      r_len       <= '0;
      r_idx       <= '0;
      r_cmd_valid <= 1'b0;
      r_last      <= 1'b0;
      r_term_ld   <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_idx       <= w_idx_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_last      <= w_last_nxt;
      r_term_ld   <= w_term_ld_nxt;
      r_cmd_err   <= w_cmd_err_nxt;
    end
  end

  // Buffer contents need no reset; only written while collecting a command.
  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      r_buf[r_len[AW-1:0]] <= i_rx_word;
    end
  end

  assign o_rx_enable   = ((r_state == RECV) || (r_state == DISCARD)) && !i_tx_active;
  assign o_cmd_valid   = r_cmd_valid;
  assign o_cmd_len     = r_len;
  assign o_rsp_ready   = w_rsp_rdy;
  assign o_cmd_err     = r_cmd_err;
  // Addresses past the buffer end read as zero.
  assign o_cmd_rd_data = (LW'(i_cmd_rd_addr) < MAX_LEN) ? r_buf[i_cmd_rd_addr] : '0;

endmodule

// File: tb/tb_uart_cmd_responder.sv
module tb_uart_cmd_responder;

  localparam int ML     = 5;
  localparam int WORD_T = 10;
  localparam int RX_T   = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       o_rx_enable;
  logic [7:0] rx_word;
  logic       rx_error, rx_done, rx_active;
  logic       o_tx_start;
  logic [7:0] o_tx_word;
  logic       tx_done, tx_active;
  logic       o_cmd_valid;
  logic [2:0] o_cmd_len;
  logic [2:0] cmd_rd_addr;
  logic [7:0] o_cmd_rd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_last;
  logic       o_rsp_ready;
  logic       o_cmd_err;

  int n_cmp = 0;
  int n_fail = 0;

  // uart model state and monitors
  logic [7:0] tx_log[$];
  int         tx_dly = 0;
  int         m_phase = 0;
  int         m_cnt = 0;
  int         m_hold = 0;
  int         m_min_hold = 1000;
  int         m_hold_err = 0;
  int         m_overlap_err = 0;
  int         n_start_rise = 0;
  int         n_err_pulse = 0;
  logic [7:0] m_w0;
  logic       prev_start = 1'b0;

  always #5 clk = ~clk;

  uart_cmd_responder #(
    .DataBits(8),
    .MaxLen  (ML)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .o_rx_enable  (o_rx_enable),
    .i_rx_word    (rx_word),
    .i_rx_error   (rx_error),
    .i_rx_done    (rx_done),
    .i_rx_active  (rx_active),
    .o_tx_start   (o_tx_start),
    .o_tx_word    (o_tx_word),
    .i_tx_done    (tx_done),
    .i_tx_active  (tx_active),
    .o_cmd_valid  (o_cmd_valid),
    .o_cmd_len    (o_cmd_len),
    .i_cmd_rd_addr(cmd_rd_addr),
    .o_cmd_rd_data(o_cmd_rd_data),
    .i_rsp_valid  (rsp_valid),
    .i_rsp_data   (rsp_data),
    .i_rsp_last   (rsp_last),
    .o_rsp_ready  (o_rsp_ready),
    .o_cmd_err    (o_cmd_err)
  );

  // Word-level uart tx model plus monitors, all evaluated on the falling edge.
  initial begin
    tx_active = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (o_tx_start === 1'b1 && rx_active) m_overlap_err++;
      if (o_tx_start === 1'b1 && prev_start !== 1'b1) n_start_rise++;
      prev_start = o_tx_start;
      if (o_cmd_err === 1'b1) n_err_pulse++;
      case (m_phase)
        0: if (o_tx_start === 1'b1) begin
          m_w0 = o_tx_word; m_cnt = 0; m_hold = 0; m_phase = 1;
        end
        1: begin
          if (o_tx_start !== 1'b1 || o_tx_word !== m_w0) m_hold_err++;
          else m_hold++;
          if (m_cnt >= tx_dly) begin
            tx_active = 1'b1;
            tx_log.push_back(m_w0);
            if (m_hold < m_min_hold) m_min_hold = m_hold;
            m_cnt = 0;
            m_phase = 2;
          end else begin
            m_cnt++;
          end
        end
        default: begin
          m_cnt++;
          if (m_cnt >= WORD_T) begin
            tx_active = 1'b0; tx_done = 1'b1; m_phase = 0;
          end
        end
      endcase
    end
  end

  // ---------------- stimulus helpers (bounded waits count as failures on expiry)
  task automatic send_byte(input logic [7:0] b, input logic err);
    int t = 0;
    while (o_rx_enable !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
    if (o_rx_enable !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL rx_enable_wait: rx_enable=%b required 1", o_rx_enable);
    end
    rx_active = 1'b1;
    repeat (RX_T) @(negedge clk);
    rx_active = 1'b0; rx_word = b; rx_error = err; rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; rx_error = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
  endtask

  task automatic wait_cmd_valid(input string tag);
    int t = 0;
    while (o_cmd_valid !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
    if (o_cmd_valid !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_cmd_valid_wait: cmd_valid=%b required 1", tag, o_cmd_valid);
    end
  endtask

  task automatic send_rsp(input logic [7:0] d, input logic last);
    int t = 0;
    while (o_rsp_ready !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
    if (o_rsp_ready !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL rsp_ready_wait: rsp_ready=%b required 1", o_rsp_ready);
    end
    rsp_valid = 1'b1; rsp_data = d; rsp_last = last;
    @(negedge clk);
    rsp_valid = 1'b0; rsp_last = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(m_phase == 0 && tx_active == 1'b0 && o_rx_enable === 1'b1) && t < 3000) begin
      @(negedge clk); t++;
    end
    if (t >= 3000) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_wait: rx_enable=%b tx_active=%b required idle", o_rx_enable, tx_active);
    end
  endtask

  // ---------------- tests
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (o_tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", o_tx_start); end
    n_cmp++; if (o_tx_word !== 8'h00) begin n_fail++; $display("FAIL reset_tx_word: got %h want 00", o_tx_word); end
    n_cmp++; if (o_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid: got %b want 0", o_cmd_valid); end
    n_cmp++; if (o_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_ready: got %b want 0", o_rsp_ready); end
    n_cmp++; if (o_cmd_err !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_err: got %b want 0", o_cmd_err); end
    n_cmp++; if (o_cmd_len !== 3'd0) begin n_fail++; $display("FAIL reset_cmd_len: got %0d want 0", o_cmd_len); end
    n_cmp++; if (o_rx_enable !== 1'b1) begin n_fail++; $display("FAIL reset_rx_enable: got %b want 1", o_rx_enable); end
  endtask

  task automatic test_basic();
    int base = tx_log.size();
    string exp;
    logic [7:0] e, g;
    send_str("AB;");
    // first echoed byte is requested in the cycle after the Terminator rx_done
    n_cmp++; if (o_tx_start !== 1'b1) begin n_fail++; $display("FAIL basic_latency_start: got %b want 1", o_tx_start); end
    n_cmp++; if (o_tx_word !== 8'h41) begin n_fail++; $display("FAIL basic_latency_word: got %h want 41", o_tx_word); end
    wait_cmd_valid("basic");
    n_cmp++; if (o_cmd_len !== 3'd2) begin n_fail++; $display("FAIL basic_cmd_len: got %0d want 2", o_cmd_len); end
    cmd_rd_addr = 3'd0; #1;
    n_cmp++; if (o_cmd_rd_data !== 8'h41) begin n_fail++; $display("FAIL basic_rd0: got %h want 41", o_cmd_rd_data); end
    cmd_rd_addr = 3'd1; #1;
    n_cmp++; if (o_cmd_rd_data !== 8'h42) begin n_fail++; $display("FAIL basic_rd1: got %h want 42", o_cmd_rd_data); end
    send_rsp(8'h37, 1'b1);
    n_cmp++; if (o_cmd_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_in_rsp: got %b want 1", o_cmd_valid); end
    wait_idle();
    n_cmp++; if (o_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_after: got %b want 0", o_cmd_valid); end
    exp = "AB:7;";
    n_cmp++; if (tx_log.size() - base !== exp.len()) begin n_fail++; $display("FAIL basic_word_count: got %0d want %0d", tx_log.size() - base, exp.len()); end
    for (int i = 0; i < exp.len(); i++) begin
      e = exp[i];
      g = (base + i < tx_log.size()) ? tx_log[base + i] : 8'hxx;
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL basic_line[%0d]: got %h want %h", i, g, e); end
    end
  endtask

  task automatic test_empty();
    int rise0 = n_start_rise;
    int bad = 0;
    send_byte(8'h3B, 1'b0);
    repeat (2 * WORD_T + 4) begin
      if (o_cmd_valid !== 1'b0 || o_cmd_err !== 1'b0) bad++;
      @(negedge clk);
    end
    n_cmp++; if (n_start_rise - rise0 !== 0) begin n_fail++; $display("FAIL empty_tx_start: got %0d starts want 0", n_start_rise - rise0); end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL empty_flags: got %0d cycles with cmd_valid/cmd_err want 0", bad); end
  endtask

  task automatic test_full_len();
    int base = tx_log.size();
    string exp;
    logic [7:0] e, g;
    send_str("ABCDE;");
    wait_cmd_valid("full");
    n_cmp++; if (o_cmd_len !== 3'd5) begin n_fail++; $display("FAIL full_cmd_len: got %0d want 5", o_cmd_len); end
    cmd_rd_addr = 3'd4; #1;
    n_cmp++; if (o_cmd_rd_data !== 8'h45) begin n_fail++; $display("FAIL full_rd4: got %h want 45", o_cmd_rd_data); end
    send_rsp(8'h5A, 1'b1);
    wait_idle();
    exp = "ABCDE:Z;";
    n_cmp++; if (tx_log.size() - base !== exp.len()) begin n_fail++; $display("FAIL full_word_count: got %0d want %0d", tx_log.size() - base, exp.len()); end
    for (int i = 0; i < exp.len(); i++) begin
      e = exp[i];
      g = (base + i < tx_log.size()) ? tx_log[base + i] : 8'hxx;
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL full_line[%0d]: got %h want %h", i, g, e); end
    end
  endtask

  task automatic test_overflow();
    int base = tx_log.size();
    int err0 = n_err_pulse;
    send_str("ABCDEF;");
    n_cmp++; if (o_cmd_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err_pulse: got %b want 1", o_cmd_err); end
    repeat (3) @(negedge clk);
    n_cmp++; if (n_err_pulse - err0 !== 1) begin n_fail++; $display("FAIL ovf_err_count: got %0d want 1", n_err_pulse - err0); end
    n_cmp++; if (tx_log.size() !== base) begin n_fail++; $display("FAIL ovf_no_tx: got %0d words want 0", tx_log.size() - base); end
    send_str("X;");
    wait_cmd_valid("ovf");
    n_cmp++; if (o_cmd_len !== 3'd1) begin n_fail++; $display("FAIL ovf_next_len: got %0d want 1", o_cmd_len); end
    n_cmp++; if (tx_log.size() - base !== 2 || tx_log[base] !== 8'h58 || tx_log[base + 1] !== 8'h3A)
      begin n_fail++; $display("FAIL ovf_next_echo: got %0d words first %h want 58 3A", tx_log.size() - base, tx_log[base]); end
    send_rsp(8'h6B, 1'b1);
    wait_idle();
  endtask

  task automatic test_rx_error();
    int base = tx_log.size();
    int err0 = n_err_pulse;
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b1);
    send_byte(8'h43, 1'b0);
    send_byte(8'h3B, 1'b0);
    n_cmp++; if (o_cmd_err !== 1'b1) begin n_fail++; $display("FAIL rxerr_err_pulse: got %b want 1", o_cmd_err); end
    repeat (3) @(negedge clk);
    n_cmp++; if (n_err_pulse - err0 !== 1) begin n_fail++; $display("FAIL rxerr_err_count: got %0d want 1", n_err_pulse - err0); end
    n_cmp++; if (tx_log.size() !== base) begin n_fail++; $display("FAIL rxerr_no_tx: got %0d words want 0", tx_log.size() - base); end
    send_str("Q;");
    wait_cmd_valid("rxerr");
    n_cmp++; if (o_cmd_len !== 3'd1) begin n_fail++; $display("FAIL rxerr_next_len: got %0d want 1", o_cmd_len); end
    n_cmp++; if (tx_log.size() - base !== 2 || tx_log[base] !== 8'h51 || tx_log[base + 1] !== 8'h3A)
      begin n_fail++; $display("FAIL rxerr_next_echo: got %0d words first %h want 51 3A", tx_log.size() - base, tx_log[base]); end
    send_rsp(8'h21, 1'b1);
    wait_idle();
  endtask

  task automatic test_slow_uart();
    int base = tx_log.size();
    int rise0 = n_start_rise;
    int herr0 = m_hold_err;
    string exp;
    logic [7:0] e, g;
    tx_dly = 5;
    m_min_hold = 1000;
    send_str("D;");
    wait_cmd_valid("slow");
    send_rsp(8'h31, 1'b1);
    wait_idle();
    tx_dly = 0;
    n_cmp++; if (m_hold_err - herr0 !== 0) begin n_fail++; $display("FAIL slow_stable: got %0d unstable cycles want 0", m_hold_err - herr0); end
    n_cmp++; if (m_min_hold < 5) begin n_fail++; $display("FAIL slow_hold: got %0d cycles want >=5", m_min_hold); end
    n_cmp++; if (n_start_rise - rise0 !== 4) begin n_fail++; $display("FAIL slow_starts: got %0d want 4", n_start_rise - rise0); end
    exp = "D:1;";
    n_cmp++; if (tx_log.size() - base !== exp.len()) begin n_fail++; $display("FAIL slow_word_count: got %0d want %0d", tx_log.size() - base, exp.len()); end
    for (int i = 0; i < exp.len(); i++) begin
      e = exp[i];
      g = (base + i < tx_log.size()) ? tx_log[base + i] : 8'hxx;
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL slow_line[%0d]: got %h want %h", i, g, e); end
    end
  endtask

  task automatic test_reset_mid_echo();
    int base = tx_log.size();
    int rise0;
    int t = 0;
    string exp;
    logic [7:0] e, g;
    send_str("HELLO;");
    while (tx_log.size() < base + 2 && t < 3000) begin @(negedge clk); t++; end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (o_tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_tx_start: got %b want 0", o_tx_start); end
    n_cmp++; if (o_tx_word !== 8'h00) begin n_fail++; $display("FAIL rst_tx_word: got %h want 00", o_tx_word); end
    n_cmp++; if (o_cmd_valid !== 1'b0 || o_rsp_ready !== 1'b0 || o_cmd_err !== 1'b0)
      begin n_fail++; $display("FAIL rst_flags: got valid=%b ready=%b err=%b want 0 0 0", o_cmd_valid, o_rsp_ready, o_cmd_err); end
    n_cmp++; if (o_rx_enable !== !tx_active) begin n_fail++; $display("FAIL rst_rx_enable: got %b want %b", o_rx_enable, !tx_active); end
    reset = 1'b0;
    rise0 = n_start_rise;
    wait_idle();
    repeat (5) @(negedge clk);
    n_cmp++; if (tx_log.size() - base !== 2) begin n_fail++; $display("FAIL rst_stray: got %0d words want 2", tx_log.size() - base); end
    n_cmp++; if (n_start_rise - rise0 !== 0) begin n_fail++; $display("FAIL rst_no_start: got %0d want 0", n_start_rise - rise0); end
    base = tx_log.size();
    send_str("OK;");
    wait_cmd_valid("rst");
    n_cmp++; if (o_cmd_len !== 3'd2) begin n_fail++; $display("FAIL rst_ok_len: got %0d want 2", o_cmd_len); end
    send_rsp(8'h79, 1'b1);
    wait_idle();
    exp = "OK:y;";
    for (int i = 0; i < exp.len(); i++) begin
      e = exp[i];
      g = (base + i < tx_log.size()) ? tx_log[base + i] : 8'hxx;
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL rst_ok_line[%0d]: got %h want %h", i, g, e); end
    end
    n_cmp++; if (m_overlap_err !== 0) begin n_fail++; $display("FAIL tx_rx_overlap: got %0d cycles want 0", m_overlap_err); end
  endtask

  initial begin
    reset = 1'b1;
    rx_word = 8'h00; rx_error = 1'b0; rx_done = 1'b0; rx_active = 1'b0;
    rsp_valid = 1'b0; rsp_data = 8'h00; rsp_last = 1'b0;
    cmd_rd_addr = 3'd0;
    test_reset();
    test_basic();
    test_empty();
    test_full_len();
    test_overflow();
    test_rx_error();
    test_slow_uart();
    test_reset_mid_echo();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
- Slave-side line protocol engine on the FIFO interface of the team's uart block, for half-duplex master/slave command links.
- Receive path: buffers received bytes until Terminator (';').
- Transmit path: echoes the command, sends Separator (':'), streams a response from user logic, then sends Terminator.
- Sits between the uart instance and application command-decode logic. Gates rx_enable and tx_start so that receive and transmit never overlap.

Parameters:
- DataBits, 8, word width; must match the uart instance.
- MaxLen, 16, command buffer depth in bytes (power of 2 not required, must be ≥1).
- Terminator, 8'h3B, end-of-message character (';').
- Separator, 8'h3A, character between echoed command and response (':').

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- rx_enable  out  1  to uart rx_enable
- rx_word  in  DataBits  from uart
- rx_error  in  1  from uart
- rx_done  in  1  from uart, 1-cycle pulse
- rx_active  in  1  from uart
- tx_start  out  1  to uart
- tx_word  out  DataBits  to uart
- tx_done  in  1  from uart, 1-cycle pulse
- tx_active  in  1  from uart
- cmd_valid  out  1  a complete command is available
- cmd_len  out  clog2(MaxLen+1)  command length in bytes, excluding Terminator
- cmd_rd_addr  in  clog2(MaxLen)  command buffer read index
- cmd_rd_data  out  DataBits  buffer[cmd_rd_addr], combinational read
- rsp_valid  in  1  response byte offered
- rsp_data  in  DataBits  response byte
- rsp_last  in  1  qualifies the final response byte
- rsp_ready  out  1  response byte accepted when rsp_valid & rsp_ready
- cmd_err  out  1  1-cycle pulse: a message was discarded (overflow or rx_error)

Behaviour:
- Reset values:
  - state = RECV, len = 0, idx = 0, tx_pend = 0.
  - tx_start = 0, tx_word = 0, cmd_valid = 0, rsp_ready = 0, cmd_err = 0.
  - rx_enable = 1 once reset deasserts, subject to tx_active.
  - Buffer contents are don't-care.
- rx_enable = (state == RECV || state == DISCARD) && !tx_active.
- All rx handling is qualified by rx_done. Bytes are sampled on the rx_done cycle.
- States:
  - RECV:
    - rx_done & rx_error -> DISCARD.
    - rx_done & word == Terminator & len == 0 -> stay in RECV (empty message ignored, no tx).
    - rx_done & word == Terminator & len > 0 -> ECHO, idx = 0.
    - rx_done & other word & len < MaxLen -> buf[len] = word, len++.
    - rx_done & other word & len == MaxLen -> DISCARD.
  - DISCARD: drop bytes. On rx_done & !rx_error & word == Terminator -> pulse cmd_err, len = 0, RECV. rx_error bytes are ignored while here.
  - ECHO: transmit buf[idx] for idx = 0..len-1, one byte per tx transaction, then -> SEP.
  - SEP: transmit Separator. On its tx_done -> RSP, and cmd_valid = 1.
  - RSP:
    - rsp_ready = !tx_pend && !tx_active && !rx_active.
    - On accept: transmit rsp_data. If rsp_last, go -> TERM after that byte's tx_done.
    - cmd_valid stays high through RSP and drops on entry to TERM.
  - TERM: transmit Terminator. On tx_done -> len = 0, RECV.
- Tx transaction (tx_pend):
  - Load tx_word and set tx_start = 1.
  - Hold tx_start and keep tx_word stable until tx_active is sampled high, then drop tx_start.
  - Wait for tx_done before loading the next byte.
  - tx_start is never asserted while rx_active = 1.
- Latency: Terminator rx_done in cycle N -> tx_start = 1 with tx_word = buf[0] in cycle N+1.
- Response with zero bytes is impossible. User logic must send at least one byte carrying rsp_last.
- cmd_rd_data is valid while cmd_valid = 1 and undefined otherwise. The buffer is not written outside RECV.
- Simultaneous events:
  - rx_done during ECHO/SEP/RSP/TERM (master protocol violation): byte ignored, and cmd_err is not pulsed.
  - tx_done and a new rsp accept cannot coincide, because rsp_ready requires !tx_pend.
- Reset mid-operation: immediate return to reset values. A word already in flight inside the uart completes on the line; the tx_done it generates after reset is ignored.

Decomposition:
- Shared package uart_pkg:
  - state enum (RECV, DISCARD, ECHO, SEP, RSP, TERM).
  - Character constants CHAR_TERM = 8'h3B and CHAR_SEP = 8'h3A.
- One sub-module, uart_tx_req: single-byte tx handshake.
  - Inputs: load, data, tx_active, tx_done.
  - Outputs: tx_start, tx_word, busy, done pulse.
  - Instantiated once.

Test Plan:
- Send "AB;" -> line carries 'A','B',':'. cmd_valid = 1, cmd_len = 2, cmd_rd_data[0] = 8'h41, cmd_rd_data[1] = 8'h42. Drive rsp "7" with rsp_last -> line carries '7',';', then cmd_valid = 0 and the block returns to RECV.
- Send ";" alone -> no tx_start for 2 full word times, cmd_valid stays 0, cmd_err stays 0.
- MaxLen = 4, send "ABCDE;" -> no tx, one cmd_err pulse after ';'. Then send "X;" -> echoes 'X',':' and cmd_len = 1.
- Inject rx_error on the 2nd byte of "ABC;" -> no tx, one cmd_err pulse at ';'. A following "Q;" is handled normally.
- uart model delays tx_active 5 cycles after tx_start -> tx_start held and tx_word stable for all 5 cycles, and exactly one word is sent per byte.
- Assert reset during the ECHO of "HELLO;" -> all outputs return to reset values next cycle, the stray tx_done is ignored, and "OK;" afterwards echoes correctly.
